// File: rtl/dmem_pkg.sv
// Shared constants and types for the line-granular data memory.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dmem_pkg;

    // Width of one cache line in bits.
    localparam int LINE_W      = 256;
    // Default request-capture-to-ack latency in cycles.
    localparam int LATENCY_DEF = 10;
    // Byte-offset bits within a line (32 bytes per 256-bit line).
    localparam int OFF_W       = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// Enable/ack request bus between the cache controller and the line memory.
// Latency: n/a (wiring only).
// Backpressure: the requester holds enable_i until ack_o; there is no ready.
//
// Signals:
//   enable_i  request valid, held until ack_o
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; bits [4:0] ignored
//   data_i    write data
//   data_o    read data, valid while ack_o=1 for a read
//   ack_o     one-cycle completion pulse
//   busy_o    memory is not idle
interface dmem_if #(
    parameter int LINE_W = dmem_pkg::LINE_W
);
    logic              enable_i;
    logic              write_i;
    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic [LINE_W-1:0] data_o;
    logic              ack_o;
    logic              busy_o;

    // Requester side (cache controller).
    modport master (
        output enable_i, write_i, addr_i, data_i,
        input  data_o, ack_o, busy_o
    );

    // Memory side.
    modport slave (
        input  enable_i, write_i, addr_i, data_i,
        output data_o, ack_o, busy_o
    );
endinterface

// File: rtl/dmem_latency_cnt.sv
// Clear/enable up-counter that flags when the access cycle has been reached.
// Latency: term is combinational from the count register; count updates on clk_i.
// Backpressure: none; counts only while en is high, clr wins over en.
//
// Ports:
//   clk_i, rst_i  clock and asynchronous active-low reset
//   clr           synchronous clear to zero
//   en            increment enable
//   term          count == LATENCY-2
module dmem_latency_cnt #(
    parameter int LATENCY = dmem_pkg::LATENCY_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic term
);

    // Wide enough to hold LATENCY-2; at least one bit for LATENCY=2.
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [CW-1:0] TERM_VAL = CW'(LATENCY - 2);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign term = (count == TERM_VAL);

endmodule

// File: rtl/dmem_line_port.sv
// Line-granular backing memory serving 256-bit reads/writes to the data cache.
// Latency: ack_o pulses LATENCY cycles after the request is captured; one idle cycle follows.
// Backpressure: one request at a time; inputs are ignored while busy_o is high.
//
// Ports:
//   clk_i   rising-edge clock
//   rst_i   asynchronous active-low reset (aborts an in-flight request)
//   bus     dmem_if slave: enable/write/addr/data in, data/ack/busy out
//
// memory[] is deliberately not reset so the system bench can preload it.
module dmem_line_port #(
    parameter int LATENCY = dmem_pkg::LATENCY_DEF,
    parameter int DEPTH   = 512,
    parameter int LINE_W  = dmem_pkg::LINE_W
) (
    input  logic   clk_i,
    input  logic   rst_i,
    dmem_if.slave  bus
);

    import dmem_pkg::*;

    localparam int IW = $clog2(DEPTH);

    logic [LINE_W-1:0] memory [0:DEPTH-1];

    state_t            state;
    logic [IW-1:0]     req_idx;
    logic              req_write;
    logic [LINE_W-1:0] req_data;
    logic [LINE_W-1:0] data_q;
    logic              ack_q;
    logic              busy_q;

    logic              cnt_term;
    logic              access;
    logic [IW-1:0]     in_idx;

    // Upper address bits are dropped so out-of-range lines alias modulo DEPTH.
    assign in_idx = bus.addr_i[OFF_W +: IW];

    logic unused_addr;
    assign unused_addr = ^{bus.addr_i[31:OFF_W+IW], bus.addr_i[OFF_W-1:0]};

    // Counter is held at zero in IDLE, so it reads 0 on the first WAIT edge.
    dmem_latency_cnt #(
        .LATENCY (LATENCY)
    ) u_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr   (state == IDLE),
        .en    (state == WAIT),
        .term  (cnt_term)
    );

    // The edge that moves WAIT -> ACK is the one that performs the access.
    assign access = (state == WAIT) && cnt_term;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            req_idx   <= '0;
            req_write <= 1'b0;
            req_data  <= '0;
            data_q    <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (bus.enable_i) begin
                        req_idx   <= in_idx;
                        req_write <= bus.write_i;
                        req_data  <= bus.data_i;
                        state     <= WAIT;
                        busy_q    <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_term) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                        if (!req_write) begin
                            data_q <= memory[req_idx];
                        end
                    end
                end
                ACK: begin
                    // Back to IDLE regardless of enable_i; this forces the idle gap.
                    state  <= IDLE;
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    ack_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Array write lives in its own un-reset block; a reset mid-request
    // forces state to IDLE asynchronously, so no commit can follow it.
    always_ff @(posedge clk_i) begin
        if (access && req_write) begin
            memory[req_idx] <= req_data;
        end
    end

    assign bus.data_o = data_q;
    assign bus.ack_o  = ack_q;
    assign bus.busy_o = busy_q;

endmodule

// File: tb/tb_dmem_line_port.sv
module tb_dmem_line_port;
    import dmem_pkg::*;

    localparam int LAT = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_if #(.LINE_W(LINE_W)) bus();

    dmem_line_port #(
        .LATENCY (LAT),
        .DEPTH   (512),
        .LINE_W  (LINE_W)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [255:0] d;
        logic [255:0] exp;   // data_o in the ack cycle (held value for writes)
        int           line;
    } vec_t;

    vec_t vecs[8];

    // Issue one request from IDLE; returns the ack index (cycles after the
    // sampling edge, 1-based) and data_o seen in the ack cycle.
    task automatic run_txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                           output int ack_at, output logic [255:0] rd, output bit busy_ok);
        @(negedge clk);
        bus.enable_i = 1'b1;
        bus.write_i  = w;
        bus.addr_i   = a;
        bus.data_i   = d;
        ack_at  = -1;
        rd      = '0;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40 && ack_at < 0; k++) begin
            @(negedge clk);
            if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
            if (bus.ack_o === 1'b1) begin
                ack_at = k;
                rd     = bus.data_o;
            end
        end
        bus.enable_i = 1'b0;
    endtask

    initial begin
        int           ack_at;
        logic [255:0] rd;
        bit           busy_ok;
        logic         busy_h [0:40];
        logic         ack_h  [0:40];
        logic [255:0] rd2;
        int           nacks;

        bus.enable_i = 1'b0;
        bus.write_i  = 1'b0;
        bus.addr_i   = '0;
        bus.data_i   = '0;

        dut.memory[0] = 256'd5;
        dut.memory[3] = 256'h3333;
        dut.memory[4] = 256'h0;
        dut.memory[5] = 256'h5555;

        vecs[0] = '{1'b0, 32'h0000_0000, 256'h0,           256'd5,           0};
        vecs[1] = '{1'b1, 32'h0000_0020, 256'hDEADBEEF,    256'd5,           1};
        vecs[2] = '{1'b0, 32'h0000_0020, 256'h0,           256'hDEADBEEF,    1};
        vecs[3] = '{1'b1, 32'h0000_4020, 256'hA5A5_0001,   256'hDEADBEEF,    1};
        vecs[4] = '{1'b0, 32'h0000_003F, 256'h0,           256'hA5A5_0001,   1};
        vecs[5] = '{1'b1, 32'h0000_0040, {8{32'h12345678}}, 256'hA5A5_0001,  2};
        vecs[6] = '{1'b0, 32'h0000_005F, 256'h0,           {8{32'h12345678}}, 2};
        vecs[7] = '{1'b0, 32'h0000_0000, 256'h0,           256'd5,           0};

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ack",  {255'b0, bus.ack_o},  256'd0);
        chk("reset_busy", {255'b0, bus.busy_o}, 256'd0);
        chk("reset_data", bus.data_o,           256'd0);
        chk("reset_mem0", dut.memory[0],        256'd5);

        // Table-driven single transactions
        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i].w, vecs[i].a, vecs[i].d, ack_at, rd, busy_ok);
            chk($sformatf("v%0d_ack_at", i), 256'(ack_at), 256'(LAT));
            chk($sformatf("v%0d_busy", i), {255'b0, busy_ok}, 256'd1);
            chk($sformatf("v%0d_data", i), rd, vecs[i].exp);
            @(negedge clk);
            chk($sformatf("v%0d_ack_gone", i), {255'b0, bus.ack_o},  256'd0);
            chk($sformatf("v%0d_idle", i),     {255'b0, bus.busy_o}, 256'd0);
            if (vecs[i].w)
                chk($sformatf("v%0d_mem", i), dut.memory[vecs[i].line], vecs[i].d);
        end

        // Inputs changed mid-WAIT, enable held through ack
        @(negedge clk);
        bus.enable_i = 1'b1;
        bus.write_i  = 1'b1;
        bus.addr_i   = 32'h80;
        bus.data_i   = 256'h1111;
        rd2 = '0;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            busy_h[k] = bus.busy_o;
            ack_h[k]  = bus.ack_o;
            if (k == 1) begin
                bus.write_i = 1'b0;
                bus.addr_i  = 32'hA0;
                bus.data_i  = 256'h9999;
            end
            if (k == 21) begin
                rd2 = bus.data_o;
                bus.enable_i = 1'b0;
            end
        end
        chk("mid_ack9",    {255'b0, ack_h[9]},   256'd0);
        chk("mid_ack10",   {255'b0, ack_h[10]},  256'd1);
        chk("mid_ack11",   {255'b0, ack_h[11]},  256'd0);
        chk("hold_busy11", {255'b0, busy_h[11]}, 256'd0);
        chk("hold_busy12", {255'b0, busy_h[12]}, 256'd1);
        chk("hold_ack21",  {255'b0, ack_h[21]},  256'd1);
        chk("hold_busy22", {255'b0, busy_h[22]}, 256'd0);
        chk("hold_rd",     rd2,                  256'h5555);
        chk("mid_mem4",    dut.memory[4],        256'h1111);
        chk("mid_mem5",    dut.memory[5],        256'h5555);

        // Reset in WAIT cycle 5 of a write to line 3
        @(negedge clk);
        bus.enable_i = 1'b1;
        bus.write_i  = 1'b1;
        bus.addr_i   = 32'h60;
        bus.data_i   = 256'hBAD;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ack",  {255'b0, bus.ack_o},  256'd0);
        chk("abort_busy", {255'b0, bus.busy_o}, 256'd0);
        chk("abort_data", bus.data_o,           256'd0);
        bus.enable_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nacks = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.ack_o === 1'b1) nacks++;
        end
        chk("abort_no_ack", 256'(nacks),   256'd0);
        chk("abort_mem3",   dut.memory[3], 256'h3333);
        run_txn(1'b0, 32'h60, 256'h0, ack_at, rd, busy_ok);
        chk("abort_rd_ack", 256'(ack_at), 256'(LAT));
        chk("abort_rd",     rd,           256'h3333);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_line_port.md
# dmem_line_port

Line-granular data memory behind the data cache. It serves 256-bit line reads and writes over an enable/ack handshake with a fixed, parameterised access latency. It is the backing store the cache controller fills from and writes back to on miss or eviction. Its storage array is backdoor-accessible to the system bench for preload and per-cycle dumps.

## Interface
- LATENCY, 10, cycles from request capture to ack (≥2)
- DEPTH, 512, number of lines
- LINE_W, 256, line width in bits
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- enable_i  in  1  request valid; held by requester until ack_o
- write_i  in  1  1 = line write, 0 = line read; sampled with enable_i
- addr_i  in  32  byte address; bits [4:0] ignored; line index = addr_i[5+log2(DEPTH)-1:5]
- data_i  in  LINE_W  write data; sampled with enable_i
- data_o  out  LINE_W  read data; valid while ack_o=1 for a read
- ack_o  out  1  one-cycle completion pulse
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- Storage is an array named `memory[0:DEPTH-1]` of LINE_W bits. Reset does not clear it; the bench preloads it by hierarchical reference.
- States: IDLE, WAIT, ACK.
- IDLE, enable_i=1 at an edge: capture index, write_i and data_i into request registers; counter←0; go to WAIT. With enable_i=0, stay in IDLE.
- WAIT: counter increments each edge.
  - At the edge where counter==LATENCY-2, go to ACK and perform the access.
  - Read: data_o←memory[idx].
  - Write: memory[idx]←captured data; data_o is unchanged.
- ACK: ack_o=1 for exactly one cycle; the next edge returns to IDLE unconditionally.
- enable_i, write_i, addr_i and data_i are ignored outside IDLE. Changes mid-transaction have no effect; only the captured request is used.
- Address bits above the index are dropped, so out-of-range addresses alias modulo DEPTH.

## Timing
- Reset (rst_i=0, any time): state=IDLE, counter=0, ack_o=0, busy_o=0, data_o=0.
  - A pending transaction is aborted. Its write is not committed and no ack is issued.
- Request sampled at edge E0:
  - busy_o=1 after E0.
  - Access performed at edge E0+LATENCY-1.
  - ack_o=1 in the cycle between E0+LATENCY-1 and E0+LATENCY.
  - IDLE after E0+LATENCY.
- Earliest next sample is edge E0+LATENCY+1, one idle cycle after ack. A requester that still holds enable_i at E0+LATENCY is not served again until E0+LATENCY+1; the cache controller must drop enable_i in the ack cycle.
- Write followed by a read of the same line returns the new data. The write is committed before its ack.
- ack_o, data_o and busy_o are registered. There is no combinational path from any input to any output.

## Structure
- Shared package `dmem_pkg` holds:
  - LINE_W and the default LATENCY;
  - the state enum {IDLE, WAIT, ACK};
  - the line offset width (5).
- One sub-module is natural: `dmem_latency_cnt`, a clear/enable up-counter with a terminal flag at LATENCY-2. The FSM, request registers and array stay in the top.

## Test plan
- Reset with memory[0]=5 preloaded: outputs are 0 after reset; memory[0] still reads 5.
- Read addr 0x0 with LATENCY=10, request at E0: ack_o high for exactly one cycle after E0+9; data_o=5 (zero-extended to 256); busy_o high from E0 through the ack cycle.
- Write addr 0x20 with data 0xDEADBEEF, then read addr 0x20: second ack returns 0xDEADBEEF; memory[1] holds it; data_o is unchanged during the write ack.
- Change addr_i and data_i during WAIT: the captured request is used. Hold enable_i through ack: no second access until E0+11.
- Drive rst_i low at WAIT cycle 5 of a write to line 3: no ack; memory[3] unchanged; outputs return to reset values.
- addr 0x4020 with DEPTH=512: aliases to line 1 (0x4020>>5 = 0x201, mod 512 = 1). addr 0x3F: low bits ignored, accesses line 1.
